axi_slave_rd: RTL and testbench
===============================

Name: axi_slave_rd

Overview:
AXI read-side slave that terminates the read address (AR) and read data (R) channels driven by the team's AXI master read interface. It accepts one AR transaction at a time and returns ar_len+1 data beats from an internal word-addressed memory, with correct r_last and r_resp. FIXED and INCR bursts are supported. WRAP, reserved and oversize requests complete with SLVERR. A backdoor write port lets the bench or system preload the memory.

Parameters:
ADDR_BITS, 32, AR address width
DATA_BITS, 32, R data width in bits; power of two, at least 8
LEN_BITS, 8, AR burst length field width
SIZE_BITS, 3, AR size field width
MEM_DEPTH, 256, memory words of DATA_BITS; power of two

Ports:
aclk  in  1  clock; all logic on rising edge
areset  in  1  synchronous, active-high reset
ar_addr  in  ADDR_BITS  read start byte address
ar_len  in  LEN_BITS  beats minus 1
ar_size  in  SIZE_BITS  bytes per beat = 2^ar_size
ar_burst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
ar_cache  in  4  accepted and ignored
ar_valid  in  1  AR valid
ar_ready  out  1  AR ready
r_data  out  DATA_BITS  read data
r_resp  out  2  00 OKAY, 10 SLVERR
r_last  out  1  final beat of burst
r_valid  out  1  R valid
r_ready  in  1  R ready
mem_we  in  1  backdoor write enable
mem_waddr  in  log2(MEM_DEPTH)  backdoor word index
mem_wdata  in  DATA_BITS  backdoor write data

Behaviour:
- All outputs are registered.
- Reset values: ar_ready=0, r_valid=0, r_last=0, r_resp=00, r_data=0. FSM goes to IDLE, beat counter to 0. Memory contents are not reset.
- Reset asserted mid-burst aborts the burst immediately; no further beats are sent.
- FSM states: IDLE and DATA.
- IDLE:
  - ar_ready=1 from the first cycle after reset deasserts.
  - An AR handshake (ar_valid & ar_ready) latches addr, len, size and burst. ar_ready drops to 0 and the FSM moves to DATA.
  - The first beat presents r_valid=1 on the cycle after the handshake (1-cycle AR-to-R latency).
- Word index = (addr >> log2(DATA_BITS/8)) mod MEM_DEPTH. Upper address bits alias.
- Error request: burst is 10 or 11, or size > log2(DATA_BITS/8).
  - Every beat returns r_resp=10 and r_data=0.
  - The burst still runs ar_len+1 beats and r_last is still asserted on the final beat.
- Normal request: r_resp=00 and r_data=mem[word index].
- Address update on each accepted beat (r_valid & r_ready):
  - INCR: addr += 2^size, wrapping at ADDR_BITS; the next word index is recomputed.
  - FIXED: addr is unchanged.
- r_data, r_resp and r_last stay stable while r_valid=1 and r_ready=0. Back-pressure of any length is legal.
- After each accepted beat the next beat is registered on the same edge, so back-to-back beats are possible with r_ready held at 1.
- Beat counter counts accepted beats, width LEN_BITS+1. r_last=1 exactly when counter == latched len.
- On acceptance of the last beat:
  - r_valid=0, r_last=0, ar_ready=1 on the next cycle; FSM returns to IDLE.
  - Minimum gap between bursts: 1 cycle of ar_ready before the next AR handshake.
- ar_len=0 produces a single beat with r_last=1.
- ar_len=2^LEN_BITS-1 produces 2^LEN_BITS beats with no counter overflow.
- AR inputs are ignored while in DATA.
- Backdoor port:
  - mem_we writes mem_wdata to mem[mem_waddr] on the edge.
  - There is no forwarding: a beat registered on the same edge as a write to the same word carries the pre-write value.
  - A value already presented on r_data does not change when the memory is written.

Test Plan:
- Reset, then preload mem[0..3]=0x11,0x22,0x33,0x44; INCR addr=0x0, len=3, size=2, r_ready=1 -> 4 consecutive beats 0x11,0x22,0x33,0x44, r_resp=00, r_last only on beat 4; first r_valid 1 cycle after the AR handshake.
- FIXED addr=0x8, len=2, size=2, mem[2]=0xA5 -> 3 beats of 0xA5, r_last on beat 3.
- INCR len=3 with r_ready toggling 1,0,0,1,0,1,1 -> r_data and r_last held stable through stalls, exactly 4 beats accepted, ar_ready=1 the cycle after the final acceptance.
- WRAP burst (10) len=1, then size=3 with DATA_BITS=32 -> each burst gives 2 (resp. len+1) beats with r_resp=10 and r_data=0, last beat has r_last=1; the FSM then returns to IDLE.
- INCR addr=0x3FC, len=1, MEM_DEPTH=256 -> beats mem[255], then mem[0] (index wrap). len=0 -> single beat with r_last=1.
- Assert areset during beat 2 of a len=7 burst -> next cycle r_valid=0 and ar_ready=0; after release ar_ready=1 and a new burst completes normally.

Source files
------------

// File: rtl/axi_slave_rd.sv
// ---------------------------------------------------------------------------
// axi_slave_rd
//   AXI read-side slave. It accepts one read request at a time on the AR
//   channel and returns ar_len+1 beats on the R channel from an internal
//   word-addressed memory. FIXED and INCR bursts return OKAY data. WRAP,
//   reserved bursts and beats wider than the data bus return SLVERR with
//   zero data, but still run the full length with r_last on the final beat.
//   A backdoor write port preloads the memory.
//
// Ports
//   aclk, areset        clock (rising edge), synchronous active-high reset
//   ar_addr/len/size    read request: start byte address, beats-1, log2 bytes
//   ar_burst/cache      burst type (00 FIXED, 01 INCR, 1x error); cache ignored
//   ar_valid/ar_ready   AR handshake
//   r_data/resp/last    read beat payload (resp 00 OKAY, 10 SLVERR)
//   r_valid/r_ready     R handshake
//   mem_we/waddr/wdata  backdoor memory write
// ---------------------------------------------------------------------------
module axi_slave_rd #(
    parameter int ADDR_BITS = 32,
    parameter int DATA_BITS = 32,
    parameter int LEN_BITS  = 8,
    parameter int SIZE_BITS = 3,
    parameter int MEM_DEPTH = 256
) (
    input  logic                         aclk,
    input  logic                         areset,
    input  logic [ADDR_BITS-1:0]         ar_addr,
    input  logic [LEN_BITS-1:0]          ar_len,
    input  logic [SIZE_BITS-1:0]         ar_size,
    input  logic [1:0]                   ar_burst,
    input  logic [3:0]                   ar_cache,
    input  logic                         ar_valid,
    output logic                         ar_ready,
    output logic [DATA_BITS-1:0]         r_data,
    output logic [1:0]                   r_resp,
    output logic                         r_last,
    output logic                         r_valid,
    input  logic                         r_ready,
    input  logic                         mem_we,
    input  logic [$clog2(MEM_DEPTH)-1:0] mem_waddr,
    input  logic [DATA_BITS-1:0]         mem_wdata
);

    localparam int IDX_BITS = $clog2(MEM_DEPTH);
    localparam int BYTE_SH  = $clog2(DATA_BITS / 8);
    localparam logic [SIZE_BITS-1:0] MAX_SIZE = SIZE_BITS'(BYTE_SH);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_DATA = 1'b1
    } state_t;

    // Word index: drop the byte offset, upper address bits alias.
    function automatic logic [IDX_BITS-1:0] word_idx(input logic [ADDR_BITS-1:0] a);
        return a[BYTE_SH +: IDX_BITS];
    endfunction

    logic [DATA_BITS-1:0] r_mem [MEM_DEPTH];

    state_t                 r_state, w_state_nx;
    logic                   r_arready, w_arready_nx;
    logic                   r_rvalid, w_rvalid_nx;
    logic                   r_rlast, w_rlast_nx;
    logic [1:0]             r_rresp, w_rresp_nx;
    logic [DATA_BITS-1:0]   r_rdata, w_rdata_nx;
    logic [LEN_BITS:0]      r_cnt, w_cnt_nx;

    // Latched request; only meaningful while in S_DATA.
    logic [ADDR_BITS-1:0]   r_addr, w_addr_nx;
    logic [LEN_BITS-1:0]    r_len, w_len_nx;
    logic [SIZE_BITS-1:0]   r_size, w_size_nx;
    logic                   r_fixed, w_fixed_nx;
    logic                   r_err, w_err_nx;

    logic                   w_ar_hs;
    logic                   w_r_hs;
    logic                   w_req_err;
    logic [ADDR_BITS-1:0]   w_step_addr;
    logic [LEN_BITS:0]      w_cnt_inc;
    logic                   w_unused;

    assign w_unused    = ^ar_cache;
    assign w_ar_hs     = ar_valid & r_arready;
    assign w_r_hs      = r_rvalid & r_ready;
    assign w_req_err   = ar_burst[1] | (ar_size > MAX_SIZE);
    assign w_step_addr = r_fixed ? r_addr : (r_addr + (ADDR_BITS'(1) << r_size));
    assign w_cnt_inc   = r_cnt + 1'b1;

    always_comb begin
        w_state_nx   = r_state;
        w_arready_nx = r_arready;
        w_rvalid_nx  = r_rvalid;
        w_rlast_nx   = r_rlast;
        w_rresp_nx   = r_rresp;
        w_rdata_nx   = r_rdata;
        w_cnt_nx     = r_cnt;
        w_addr_nx    = r_addr;
        w_len_nx     = r_len;
        w_size_nx    = r_size;
        w_fixed_nx   = r_fixed;
        w_err_nx     = r_err;

        case (r_state)
            S_IDLE: begin
                w_arready_nx = 1'b1;
                if (w_ar_hs) begin
                    // First beat is registered on the handshake edge.
                    w_state_nx   = S_DATA;
                    w_arready_nx = 1'b0;
                    w_addr_nx    = ar_addr;
                    w_len_nx     = ar_len;
                    w_size_nx    = ar_size;
                    w_fixed_nx   = (ar_burst == 2'b00);
                    w_err_nx     = w_req_err;
                    w_rvalid_nx  = 1'b1;
                    w_rresp_nx   = w_req_err ? 2'b10 : 2'b00;
                    w_rdata_nx   = w_req_err ? '0 : r_mem[word_idx(ar_addr)];
                    w_rlast_nx   = (ar_len == '0);
                    w_cnt_nx     = '0;
                end
            end
            S_DATA: begin
                if (w_r_hs) begin
                    if (r_rlast) begin
                        w_state_nx   = S_IDLE;
                        w_rvalid_nx  = 1'b0;
                        w_rlast_nx   = 1'b0;
                        w_arready_nx = 1'b1;
                        w_cnt_nx     = '0;
                    end else begin
                        // Next beat registered on the accepting edge.
                        w_addr_nx  = w_step_addr;
                        w_cnt_nx   = w_cnt_inc;
                        w_rdata_nx = r_err ? '0 : r_mem[word_idx(w_step_addr)];
                        w_rlast_nx = (w_cnt_inc == {1'b0, r_len});
                    end
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state   <= S_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_rresp   <= 2'b00;
            r_rdata   <= '0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_arready <= w_arready_nx;
            r_rvalid  <= w_rvalid_nx;
            r_rlast   <= w_rlast_nx;
            r_rresp   <= w_rresp_nx;
            r_rdata   <= w_rdata_nx;
            r_cnt     <= w_cnt_nx;
        end
    end

    always_ff @(posedge aclk) begin
        r_addr  <= w_addr_nx;
        r_len   <= w_len_nx;
        r_size  <= w_size_nx;
        r_fixed <= w_fixed_nx;
        r_err   <= w_err_nx;
    end

    // Backdoor write; reads above see the pre-write contents on this edge.
    always_ff @(posedge aclk) begin
        if (mem_we) begin
            r_mem[mem_waddr] <= mem_wdata;
        end
    end

    assign ar_ready = r_arready;
    assign r_valid  = r_rvalid;
    assign r_last   = r_rlast;
    assign r_resp   = r_rresp;
    assign r_data   = r_rdata;

endmodule

// File: tb/tb_axi_slave_rd.sv
module tb_axi_slave_rd;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    logic        aclk = 1'b0;
    logic        areset;
    logic [31:0] ar_addr;
    logic [7:0]  ar_len;
    logic [2:0]  ar_size;
    logic [1:0]  ar_burst;
    logic [3:0]  ar_cache;
    logic        ar_valid;
    logic        ar_ready;
    logic [31:0] r_data;
    logic [1:0]  r_resp;
    logic        r_last;
    logic        r_valid;
    logic        r_ready;
    logic        mem_we;
    logic [7:0]  mem_waddr;
    logic [31:0] mem_wdata;

    logic [31:0] mem_m [256];
    beat_t       sb [$];
    int          n_total = 0;
    int          n_pass  = 0;
    int          beats_acc = 0;

    always #5 aclk = ~aclk;

    axi_slave_rd dut (
        .aclk      (aclk),
        .areset    (areset),
        .ar_addr   (ar_addr),
        .ar_len    (ar_len),
        .ar_size   (ar_size),
        .ar_burst  (ar_burst),
        .ar_cache  (ar_cache),
        .ar_valid  (ar_valid),
        .ar_ready  (ar_ready),
        .r_data    (r_data),
        .r_resp    (r_resp),
        .r_last    (r_last),
        .r_valid   (r_valid),
        .r_ready   (r_ready),
        .mem_we    (mem_we),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Scoreboard: every accepted beat is compared against the oldest expectation.
    always @(negedge aclk) begin
        if (areset === 1'b0 && r_valid === 1'b1 && r_ready === 1'b1) begin
            beats_acc++;
            if (sb.size() == 0) begin
                chk("unexpected_beat", 1, 0);
            end else begin
                beat_t e;
                e = sb.pop_front();
                chk("r_data", r_data, e.data);
                chk("r_resp", r_resp, e.resp);
                chk("r_last", r_last, e.last);
            end
        end
    end

    task automatic mem_write(input int idx, input logic [31:0] val);
        mem_we    = 1'b1;
        mem_waddr = idx[7:0];
        mem_wdata = val;
        mem_m[idx] = val;
        tick();
        mem_we = 1'b0;
    endtask

    // Issue one request; expected beats go into the scoreboard before the handshake edge.
    task automatic do_ar(input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
        int          n;
        logic [31:0] a;
        logic        err;
        beat_t       e;
        ar_addr  = addr;
        ar_len   = len;
        ar_size  = size;
        ar_burst = burst;
        ar_cache = 4'hA;
        ar_valid = 1'b1;
        n = 0;
        while (ar_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) chk("ar_ready_timeout", 0, 1);
        err = burst[1] || (size > 3'd2);
        a = addr;
        for (int i = 0; i <= int'(len); i++) begin
            e.data = err ? 32'h0 : mem_m[(a >> 2) % 256];
            e.resp = err ? 2'b10 : 2'b00;
            e.last = (i == int'(len));
            sb.push_back(e);
            if (burst == 2'b01) a = a + (32'd1 << size);
        end
        tick();
        ar_valid = 1'b0;
        ar_addr  = 32'hDEAD_BEEF;
        chk("first_beat_latency", r_valid, 1);
        chk("ar_ready_low_in_data", ar_ready, 0);
    endtask

    // Run until the scoreboard is empty; returns the number of cycles taken.
    task automatic drain(output int n);
        n = 0;
        while (sb.size() != 0 && n < 2000) begin
            tick();
            n++;
        end
        if (n >= 2000) chk("drain_timeout", 0, 1);
        chk("idle_r_valid", r_valid, 0);
        chk("idle_ar_ready", ar_ready, 1);
    endtask

    initial begin
        int    n;
        int    base;
        logic  pat [7];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

        areset   = 1'b1;
        ar_addr  = '0;
        ar_len   = '0;
        ar_size  = '0;
        ar_burst = '0;
        ar_cache = '0;
        ar_valid = 1'b0;
        r_ready  = 1'b1;
        mem_we   = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        for (int i = 0; i < 256; i++) mem_m[i] = 32'h0;
        tick();
        tick();
        chk("rst_ar_ready", ar_ready, 0);
        chk("rst_r_valid", r_valid, 0);
        chk("rst_r_last", r_last, 0);
        chk("rst_r_resp", r_resp, 0);
        chk("rst_r_data", r_data, 0);
        areset = 1'b0;
        tick();
        chk("ar_ready_after_rst", ar_ready, 1);

        for (int i = 0; i < 256; i++) mem_write(i, 32'hC000_0000 + i);
        mem_write(0, 32'h11);
        mem_write(1, 32'h22);
        mem_write(2, 32'h33);
        mem_write(3, 32'h44);

        // INCR 4 beats, back-to-back
        do_ar(32'h0, 8'd3, 3'd2, 2'b01);
        drain(n);
        chk("incr_b2b_cycles", n, 4);

        // FIXED 3 beats of one word
        mem_write(2, 32'hA5);
        do_ar(32'h8, 8'd2, 3'd2, 2'b00);
        drain(n);
        chk("fixed_cycles", n, 3);

        // INCR with back-pressure
        base = beats_acc;
        do_ar(32'h10, 8'd3, 3'd2, 2'b01);
        for (int i = 0; i < 7; i++) begin
            r_ready = pat[i];
            if (!pat[i] && sb.size() != 0) begin
                chk("stall_data", r_data, sb[0].data);
                chk("stall_last", r_last, sb[0].last);
                chk("stall_valid", r_valid, 1);
            end
            tick();
        end
        r_ready = 1'b1;
        drain(n);
        chk("stall_beats", beats_acc - base, 4);

        // WRAP and oversize size -> SLVERR
        do_ar(32'h4, 8'd1, 3'd2, 2'b10);
        drain(n);
        do_ar(32'h0, 8'd2, 3'd3, 2'b01);
        drain(n);
        do_ar(32'h0, 8'd0, 3'd2, 2'b11);
        drain(n);

        // Index wrap and single-beat burst
        mem_write(255, 32'hFFEE_0001);
        do_ar(32'h3FC, 8'd1, 3'd2, 2'b01);
        drain(n);
        do_ar(32'h1C, 8'd0, 3'd2, 2'b01);
        drain(n);
        chk("len0_cycles", n, 1);

        // Sub-word INCR: four 1-byte beats share one word, then the next word
        do_ar(32'h20, 8'd4, 3'd0, 2'b01);
        drain(n);

        // Maximum length
        do_ar(32'h0, 8'd255, 3'd2, 2'b01);
        drain(n);
        chk("len255_cycles", n, 256);

        // Reset during beat 2 of an 8-beat burst
        do_ar(32'h40, 8'd7, 3'd2, 2'b01);
        tick();
        areset = 1'b1;
        tick();
        chk("midrst_r_valid", r_valid, 0);
        chk("midrst_ar_ready", ar_ready, 0);
        sb.delete();
        areset = 1'b0;
        tick();
        chk("postrst_ar_ready", ar_ready, 1);
        do_ar(32'h4, 8'd2, 3'd2, 2'b01);
        drain(n);
        chk("postrst_cycles", n, 3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
